// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
//
// Drives all eight {in1,in2,in3} input combinations, in ascending order, into
// a 3-input combinational gate. For each row it holds the drive for SETTLE
// cycles and then samples the gate output on 3 consecutive cycles. A 2-of-3
// majority vote of those samples becomes the measured truth-table bit for
// the row. The block compares the measured table with EXPECTED.
//
// Parameters
//   SETTLE   : hold cycles per row before sampling (legal range 1..255)
//   EXPECTED : reference truth table; bit (7-row) holds the result for row
//              {in1,in2,in3}, so row 000 maps to bit 7
//
// Ports
//   clk            in   rising-edge clock
//   reset_n        in   synchronous active-low reset
//   start          in   begin a sweep (accepted only in IDLE or DONE)
//   abort          in   cancel a sweep in progress (returns to IDLE)
//   out            in   output of the gate under test
//   in1,in2,in3    out  registered drive to the gate (in1 = row MSB)
//   busy           out  high while sweeping
//   done           out  level, high from completion until next start/reset
//   pass           out  measured == EXPECTED, only while done is high
//   measured       out  captured truth table
//   mismatch_count out  number of rows differing from EXPECTED
//   first_fail_row out  lowest mismatching row (0 if there is none)
//   dbg_state      out  current FSM state, for observation only
//
// Handshake: start and abort are level-sampled request strobes. No
// acknowledge is returned. Accepting start is visible as busy rising, and
// completion is visible as done rising. abort has priority over start.
// -----------------------------------------------------------------------------
module truth_table_sweeper #(
   parameter int unsigned SETTLE   = 4,
   parameter logic [7:0]  EXPECTED = 8'hED
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       abort,
   input  logic       out,
   output logic       in1,
   output logic       in2,
   output logic       in3,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] measured,
   output logic [3:0] mismatch_count,
   output logic [2:0] first_fail_row,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DWELL  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

   state_t     state;
   logic [2:0] row;
   logic [7:0] settle_cnt;
   logic [1:0] samp_idx;
   logic [1:0] samp;       // first two samples of the current row

   logic [2:0] bit_idx;
   logic [2:0] next_row;
   logic       vote;
   logic       miss;
   logic [7:0] meas_upd;

   // The third sample is taken straight from 'out' on the edge that ends the
   // sample window. This makes the vote available on that same edge.
   always_comb begin
      bit_idx  = 3'd7 - row;
      next_row = row + 3'd1;
      vote     = (samp[0] & samp[1]) | (samp[0] & out) | (samp[1] & out);
      miss     = (vote != EXPECTED[bit_idx]);
      meas_upd = measured;
      meas_upd[bit_idx] = vote;
   end

   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state          <= IDLE;
         row            <= 3'd0;
         settle_cnt     <= 8'd0;
         samp_idx       <= 2'd0;
         samp           <= 2'b00;
         {in1, in2, in3} <= 3'b000;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         measured       <= 8'd0;
         mismatch_count <= 4'd0;
         first_fail_row <= 3'd0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state          <= DWELL;
                  row            <= 3'd0;
                  settle_cnt     <= 8'd0;
                  samp_idx       <= 2'd0;
                  {in1, in2, in3} <= 3'b000;
                  busy           <= 1'b1;
                  done           <= 1'b0;
                  pass           <= 1'b0;
                  measured       <= 8'd0;
                  mismatch_count <= 4'd0;
                  first_fail_row <= 3'd0;
               end
            end

            DWELL: begin
               if (abort) begin
                  state          <= IDLE;
                  settle_cnt     <= 8'd0;
                  {in1, in2, in3} <= 3'b000;
                  busy           <= 1'b0;
                  done           <= 1'b0;
                  pass           <= 1'b0;
               end else if (settle_cnt == SETTLE_LAST) begin
                  state      <= SAMPLE;
                  settle_cnt <= 8'd0;
                  samp_idx   <= 2'd0;
               end else begin
                  settle_cnt <= settle_cnt + 8'd1;
               end
            end

            SAMPLE: begin
               if (abort) begin
                  state          <= IDLE;
                  samp_idx       <= 2'd0;
                  {in1, in2, in3} <= 3'b000;
                  busy           <= 1'b0;
                  done           <= 1'b0;
                  pass           <= 1'b0;
               end else if (samp_idx != 2'd2) begin
                  samp[samp_idx[0]] <= out;
                  samp_idx          <= samp_idx + 2'd1;
               end else begin
                  // End of the row: commit the vote and advance to the next row.
                  measured <= meas_upd;
                  samp_idx <= 2'd0;
                  if (miss) begin
                     mismatch_count <= mismatch_count + 4'd1;
                     if (mismatch_count == 4'd0)
                        first_fail_row <= row;
                  end
                  if (row != 3'd7) begin
                     row            <= next_row;
                     {in1, in2, in3} <= next_row;
                     state          <= DWELL;
                  end else begin
                     // The drive stays at 111 while the block is in DONE.
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= (meas_upd == EXPECTED);
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequential stimulus-and-capture stage that sits directly upstream of a 3-input combinational logic gate (default: the 0xED gate) and consumes that gate's single output. On `start` it drives all eight `{in1,in2,in3}` combinations in ascending order. For each vector it holds the drive for a settle window, then majority-samples the gate output. It assembles the measured 8-bit truth table and compares it against an expected code. It is used as the on-chip self-check wrapper for synthesized genetic-logic gates.

## Interface
- `SETTLE`, 4: cycles each vector is held before sampling begins; legal range 1..255; 0 is illegal.
- `EXPECTED`, 8'hED: expected truth table; bit (7−row) is the output for row `{in1,in2,in3}`, so row 000 maps to bit 7.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: begin a sweep; sampled only in IDLE or DONE.
- `abort` in 1: cancel the sweep in progress.
- `out` in 1: output of the gate under test.
- `in1`, `in2`, `in3` out 1 each: registered drive to the gate; `in1` is the MSB of the row index.
- `busy` out 1: high while sweeping.
- `done` out 1: level; high from sweep completion until the next `start` or reset.
- `pass` out 1: `measured == EXPECTED`; valid only while `done` is high, otherwise 0.
- `measured` out 8: captured truth table.
- `mismatch_count` out 4: number of rows differing from `EXPECTED` (0..8).
- `first_fail_row` out 3: lowest mismatching row; 0 when `mismatch_count` is 0.

## Operation
- States: IDLE, DWELL, SAMPLE, DONE.
- Reset (`reset_n` low at an edge):
  - State goes to IDLE.
  - `in1..in3` = 000, `busy` = 0, `done` = 0, `pass` = 0.
  - `measured` = 0, `mismatch_count` = 0, `first_fail_row` = 0.
  - Reset overrides `start` and `abort` in the same cycle.
- IDLE or DONE with `start` = 1 → DWELL. On that edge:
  - row = 0, drive = 000, settle counter = 0.
  - `measured`, `mismatch_count`, `first_fail_row`, `done` and `pass` are cleared.
  - `busy` = 1.
- DWELL: count `SETTLE` cycles with the drive held, then go to SAMPLE.
- SAMPLE: register `out` on 3 consecutive cycles. On the edge ending the third sample cycle:
  - The 2-of-3 majority vote is written to `measured[7−row]`.
  - If the vote ≠ `EXPECTED[7−row]`, `mismatch_count` increments. If this is the first mismatch, `first_fail_row` = row.
  - If row < 7: row increments, drive updates to the new row, next state is DWELL.
  - If row = 7: next state is DONE with `busy` = 0 and `done` = 1. `pass` is computed from the final `measured`, including the row-7 vote.
- DONE: the drive stays at 111 and all results hold.
- `start` while in DWELL or SAMPLE is ignored.
- `abort` = 1 in DWELL or SAMPLE → IDLE at the next edge:
  - drive = 000, `busy` = 0, `done` = 0, `pass` = 0.
  - `measured` keeps its partial contents.
- `abort` in IDLE or DONE has no effect.
- If `abort` and `start` are both high in DWELL or SAMPLE, `abort` wins.
- The row counter does not wrap: after row 7 the block always goes to DONE.
- `out` is treated as synchronous to `clk`. The gate under test is combinational, and the settle window absorbs its propagation delay.

## Timing
- Let t0 be the edge at which `start` is sampled high.
- Row r is driven from cycle t0+1+r·(SETTLE+3).
- Row r is sampled at cycle offsets SETTLE+1 .. SETTLE+3 within its window.
- `done` and `pass` become valid at cycle t0 + 8·(SETTLE+3) + 1. With `SETTLE` = 4 that is t0+57.
- `busy` is high for exactly 8·(SETTLE+3) cycles.
- Drive changes occur only on row-boundary edges, so there are no intra-row glitches on `in1..in3`.
- A restart from DONE follows the same timing. `done` falls on the edge that accepts `start`.

## Test plan
- Ideal 0xED gate model, `SETTLE` = 4, `start` pulse → drive sequence 000..111 with a 7-cycle pitch; `done` at t0+57; `measured` = 0xED, `pass` = 1, `mismatch_count` = 0.
- Gate stuck at 1 → `measured` = 0xFF, `mismatch_count` = 2, `first_fail_row` = 3, `pass` = 0.
- Ideal gate, but `out` forced to 0 for only the second sample cycle of row 5 → majority gives 1; `measured` = 0xED, `pass` = 1.
- `abort` asserted during DWELL of row 4 → `busy` = 0 next cycle; drive = 000; `done` stays 0; `measured[7:4]` = 4'b1110, matching `EXPECTED`[7:4]. A new `start` then yields a full sweep with `measured` = 0xED.
- `reset_n` low during SAMPLE of row 2 → every output takes its reset value on the next edge; `start` pulses asserted while busy, before the reset, do not restart the row sequence.
- From DONE with `pass` = 1, a `start` pulse → `done` and `pass` clear on the accepting edge, and a second identical sweep completes 57 cycles later.
